// File: rtl/cpu7_csr_req_pkg.sv
// Shared encodings and payload types for the execute-stage CSR access initiator.
package cpu7_csr_req_pkg;

  localparam int unsigned GRLEN   = 32;
  localparam int unsigned CSR_BIT = 14;
  localparam int unsigned GPR_IDX = 5;

  typedef enum logic [1:0] {
    CSR_OP_RD   = 2'b00,
    CSR_OP_WR   = 2'b01,
    CSR_OP_XCHG = 2'b10,
    CSR_OP_RSV  = 2'b11
  } csr_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10,
    ST_RESP  = 2'b11
  } csr_state_e;

  // Decoded CSR op as latched at the accept edge.
  typedef struct packed {
    csr_op_e              kind;
    logic [CSR_BIT-1:0]   num;
    logic [GRLEN-1:0]     rd_val;
    logic [GRLEN-1:0]     mask;
    logic [GPR_IDX-1:0]   rd_idx;
  } csr_op_t;

  function automatic logic op_has_write(input csr_op_e kind);
    return (kind == CSR_OP_WR) || (kind == CSR_OP_XCHG);
  endfunction

endpackage

// File: rtl/cpu7_csr_wdata_merge.sv
// Write-data selection: plain write, or masked merge of new and old CSR bits for CSRXCHG.
module cpu7_csr_wdata_merge
  import cpu7_csr_req_pkg::*;
(
  input  logic [GRLEN-1:0] rd_val,
  input  logic [GRLEN-1:0] mask,
  input  logic [GRLEN-1:0] old,
  input  logic             is_xchg,
  output logic [GRLEN-1:0] wdata
);

  always_comb begin
    wdata = rd_val;
    if (is_xchg) begin
      wdata = (rd_val & mask) | (old & ~mask);
    end
  end

endmodule

// File: rtl/cpu7_csr_req.sv
// CSR access initiator: accepts one decoded CSR op, reads then optionally writes the
// CSR file, and returns the pre-write value for rd writeback; flush aborts in-flight ops.
module cpu7_csr_req
  import cpu7_csr_req_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                op_valid,
  output logic                op_ready,
  input  logic [1:0]          op_type,
  input  logic [CSR_BIT-1:0]  op_csr_num,
  input  logic [GRLEN-1:0]    op_rd_val,
  input  logic [GRLEN-1:0]    op_rj_mask,
  input  logic [GPR_IDX-1:0]  op_rd_idx,
  output logic [CSR_BIT-1:0]  csr_raddr,
  input  logic [GRLEN-1:0]    csr_rdata,
  output logic [CSR_BIT-1:0]  csr_waddr,
  output logic [GRLEN-1:0]    csr_wdata,
  output logic                csr_wen,
  input  logic                ecl_csr_flush,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [GPR_IDX-1:0]  res_rd_idx,
  output logic [GRLEN-1:0]    res_data
);

  csr_state_e       state_q, state_d;
  csr_op_t          op_q;
  logic [GRLEN-1:0] old_q;
  logic [GRLEN-1:0] merge_wdata;
  logic             op_accept;

  assign op_accept = op_valid & op_ready;

  // State, latched op and captured old value.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      old_q   <= '0;
    end else begin
      state_q <= state_d;
      if (op_accept) begin
        op_q.kind   <= csr_op_e'(op_type);
        op_q.num    <= op_csr_num;
        op_q.rd_val <= op_rd_val;
        op_q.mask   <= op_rj_mask;
        op_q.rd_idx <= op_rd_idx;
      end
      if (state_q == ST_READ) begin
        old_q <= csr_rdata;
      end
    end
  end

  // Next state; flush pulls any in-flight op back to IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (op_accept) state_d = ST_READ;
      ST_READ:  state_d = op_has_write(op_q.kind) ? ST_WRITE : ST_RESP;
      ST_WRITE: state_d = ST_RESP;
      ST_RESP:  if (res_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (ecl_csr_flush && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end
  end

  cpu7_csr_wdata_merge u_wdata_merge (
    .rd_val  (op_q.rd_val),
    .mask    (op_q.mask),
    .old     (old_q),
    .is_xchg (op_q.kind == CSR_OP_XCHG),
    .wdata   (merge_wdata)
  );

  // Port drive is a decode of state; address/data buses sit at zero outside their state.
  always_comb begin
    op_ready   = 1'b0;
    csr_raddr  = '0;
    csr_waddr  = '0;
    csr_wdata  = '0;
    csr_wen    = 1'b0;
    res_valid  = 1'b0;
    res_data   = '0;
    res_rd_idx = '0;
    unique case (state_q)
      ST_IDLE: begin
        op_ready = ~ecl_csr_flush;
      end
      ST_READ: begin
        csr_raddr = op_q.num;
      end
      ST_WRITE: begin
        csr_waddr = op_q.num;
        csr_wdata = merge_wdata;
        // A write in a flush or reset cycle would commit a killed op.
        csr_wen   = ~ecl_csr_flush & ~reset;
      end
      ST_RESP: begin
        res_valid  = ~ecl_csr_flush;
        res_data   = old_q;
        res_rd_idx = op_q.rd_idx;
      end
      default: begin
        op_ready = 1'b0;
      end
    endcase
  end

endmodule
